// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - shared types and default constants for the count controller
//
// Package count_pkg: the FSM state enumeration and the default parameter
// values used by count_ctrl and tick_gen.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DIV_DEFAULT  = 50_000_000;
  localparam int MAXV_DEFAULT = 59;
  localparam int W_DEFAULT    = 6;

endpackage

// File: rtl/count_ctrl_tick_gen.sv
// rtl/count_ctrl_tick_gen.sv - prescaler producing one step strobe every DIV enabled cycles
//
// Module tick_gen
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, clears the prescaler
//   en      : advance the prescaler this cycle (hold when low)
//   restart : force the prescaler back to 0 (wins over en)
//   tick    : combinational, high in the cycle the prescaler sits at DIV-1
//             while enabled; the parent registers it
module tick_gen
  import count_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (restart) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

  // A restart in the same cycle discards the step that would have fired.
  assign tick = en && !restart && (presc == LAST);

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - start/stop/pause up/down counter with prescaled tick
//
// Module count_ctrl (optional macro COUNT_CTRL_SYNC_EN: start, stop, clear and
// load pass a 2-flop synchronizer and rising-edge detect, 2 cycles of latency,
// one action per press; undefined = inputs used directly as sync pulses)
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : start / resume request
//   stop     : pause request
//   clear    : return count to 0 and go to IDLE
//   up_dn    : direction, 1 = up, 0 = down
//   load     : load load_val (saturated to MAXV) into count, state unchanged
//   load_val : preset value
//   count    : current value, 0..MAXV
//   tick     : registered one-cycle pulse on every count step
//   wrap     : registered one-cycle pulse with tick when count rolls over
//   running  : high while the state register holds RUN
module count_ctrl
  import count_pkg::*;
#(
  parameter int DIV  = DIV_DEFAULT,
  parameter int MAXV = MAXV_DEFAULT,
  parameter int W    = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tick,
  output logic         wrap,
  output logic         running
);

  localparam logic [W-1:0] MAX_C = W'(MAXV);

  logic start_p, stop_p, clear_p, load_p;

`ifdef COUNT_CTRL_SYNC_EN
  logic [3:0] sync1, sync2, prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {start, stop, clear, load};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Rising edge of the synchronized level: a held button acts only once.
  assign {start_p, stop_p, clear_p, load_p} = sync2 & ~prev;
`else
  assign {start_p, stop_p, clear_p, load_p} = {start, stop, clear, load};
`endif

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clear > load > stop > start; a stop request blocks start in every state.
  always_comb begin
    state_nxt = state;
    if (clear_p) begin
      state_nxt = IDLE;
    end else if (load_p) begin
      state_nxt = state;
    end else if (stop_p) begin
      if (state == RUN) state_nxt = PAUSE;
    end else if (start_p) begin
      if (state != RUN) state_nxt = RUN;
    end
  end

  logic restart, step;

  // Leaving IDLE discards prescaler progress; resuming from PAUSE keeps it.
  assign restart = clear_p || load_p || (state == IDLE && state_nxt == RUN);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state == RUN),
    .restart (restart),
    .tick    (step)
  );

  logic [W-1:0] load_sat;
  assign load_sat = (load_val > MAX_C) ? MAX_C : load_val;

  logic tick_q, wrap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear_p) begin
        count <= '0;
      end else if (load_p) begin
        count <= load_sat;
      end else if (step) begin
        tick_q <= 1'b1;
        if (up_dn) begin
          if (count == MAX_C) begin
            count  <= '0;
            wrap_q <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          if (count == '0) begin
            count  <= MAX_C;
            wrap_q <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = (state == RUN);

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - self-checking bench for count_ctrl (DIV=4, MAXV=59)
module tb_count_ctrl;

  localparam int DIV  = 4;
  localparam int MAXV = 59;
`ifdef COUNT_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk;
  logic       rst;
  logic       start, stop, clear, up_dn, load;
  logic [5:0] load_val;
  logic [5:0] count;
  logic       tick, wrap, running;

  count_ctrl #(.DIV(DIV), .MAXV(MAXV), .W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tick     (tick),
    .wrap     (wrap),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode, prescaler phase and value in plain arithmetic.
  int m_state, m_presc, m_count;
  bit m_tick, m_wrap;
`ifdef COUNT_CTRL_SYNC_EN
  // Raw input history: [0] = previous cycle, [1] = two ago, [2] = three ago.
  bit [2:0] hs_start, hs_stop, hs_clear, hs_load;
`endif

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_presc = 0;
    m_count = 0;
    m_tick  = 0;
    m_wrap  = 0;
`ifdef COUNT_CTRL_SYNC_EN
    hs_start = 0; hs_stop = 0; hs_clear = 0; hs_load = 0;
`endif
  endtask

  task automatic model_step(input bit s, input bit p, input bit c, input bit l,
                            input bit u, input int lv);
    bit es, ep, ec, el;
`ifdef COUNT_CTRL_SYNC_EN
    es = hs_start[1] & ~hs_start[2];
    ep = hs_stop[1]  & ~hs_stop[2];
    ec = hs_clear[1] & ~hs_clear[2];
    el = hs_load[1]  & ~hs_load[2];
    hs_start = {hs_start[1:0], s};
    hs_stop  = {hs_stop[1:0], p};
    hs_clear = {hs_clear[1:0], c};
    hs_load  = {hs_load[1:0], l};
`else
    es = s; ep = p; ec = c; el = l;
`endif
    m_tick = 0;
    m_wrap = 0;
    if (ec) begin
      m_state = M_IDLE;
      m_presc = 0;
      m_count = 0;
    end else if (el) begin
      m_count = (lv > MAXV) ? MAXV : lv;
      m_presc = 0;
    end else begin
      if (m_state == M_RUN) begin
        m_presc++;
        if (m_presc == DIV) begin
          m_presc = 0;
          m_tick  = 1;
          if (u) begin
            m_wrap  = (m_count == MAXV);
            m_count = (m_count + 1) % (MAXV + 1);
          end else begin
            m_wrap  = (m_count == 0);
            m_count = (m_count + MAXV) % (MAXV + 1);
          end
        end
      end
      if (ep) begin
        if (m_state == M_RUN) m_state = M_PAUSE;
      end else if (es && m_state != M_RUN) begin
        if (m_state == M_IDLE) m_presc = 0;
        m_state = M_RUN;
      end
    end
  endtask

  // Called at a falling edge: apply inputs, clock once, compare at next falling edge.
  task automatic drive(input bit s, input bit p, input bit c, input bit l,
                       input bit u, input int lv);
    start = s; stop = p; clear = c; load = l; up_dn = u; load_val = 6'(lv);
    model_step(s, p, c, l, u, lv);
    @(posedge clk);
    @(negedge clk);
    chk("count", int'(count), m_count);
    chk("tick", int'(tick), int'(m_tick));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("running", int'(running), int'(m_state == M_RUN));
  endtask

  task automatic idle(input bit u);
    drive(0, 0, 0, 0, u, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    start = 0; stop = 0; clear = 0; load = 0; up_dn = 1; load_val = 0;
    model_reset();
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_running", int'(running), 0);
    @(negedge clk);
    rst = 1;
  endtask

  typedef struct {
    bit s, p, c, l, u;
    int lv;
    int ec;
    bit et, ew, er;
  } vec_t;

  initial begin
    vec_t tbl[26];
    int   k;
    bit   seen;

    rst = 0;
    start = 0; stop = 0; clear = 0; load = 0; up_dn = 1; load_val = 0;

    tbl = '{
      '{1,0,0,0,1, 0,  0,0,0,1},
      '{0,0,0,0,1, 0,  0,0,0,1},
      '{0,0,0,0,1, 0,  0,0,0,1},
      '{0,0,0,0,1, 0,  0,0,0,1},
      '{0,0,0,0,1, 0,  1,1,0,1},
      '{0,0,0,0,1, 0,  1,0,0,1},
      '{0,0,0,0,1, 0,  1,0,0,1},
      '{0,0,0,0,1, 0,  1,0,0,1},
      '{0,0,0,0,1, 0,  2,1,0,1},
      '{0,0,0,1,1, 58, 58,0,0,1},
      '{0,0,0,0,1, 0,  58,0,0,1},
      '{0,0,0,0,1, 0,  58,0,0,1},
      '{0,0,0,0,1, 0,  58,0,0,1},
      '{0,0,0,0,1, 0,  59,1,0,1},
      '{0,0,0,0,1, 0,  59,0,0,1},
      '{0,0,0,0,1, 0,  59,0,0,1},
      '{0,0,0,0,1, 0,  59,0,0,1},
      '{0,0,0,0,1, 0,  0,1,1,1},
      '{0,0,0,0,0, 0,  0,0,0,1},
      '{0,0,0,0,0, 0,  0,0,0,1},
      '{0,0,0,0,0, 0,  0,0,0,1},
      '{0,0,0,0,0, 0,  59,1,1,1},
      '{0,0,0,1,0, 63, 59,0,0,1},
      '{0,0,1,1,0, 10, 0,0,0,0},
      '{0,0,0,0,0, 0,  0,0,0,0},
      '{0,1,0,0,0, 0,  0,0,0,0}
    };

`ifndef COUNT_CTRL_SYNC_EN
    // Directed table: start, first tick, load 58 and up-wrap, down-wrap,
    // saturated load, clear beating load.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l, tbl[i].u, tbl[i].lv);
      chk($sformatf("row%0d_count", i), int'(count), tbl[i].ec);
      chk($sformatf("row%0d_tick", i), int'(tick), int'(tbl[i].et));
      chk($sformatf("row%0d_wrap", i), int'(wrap), int'(tbl[i].ew));
      chk($sformatf("row%0d_running", i), int'(running), int'(tbl[i].er));
    end
`endif

    // Pause with prescaler at 2, hold 10 cycles, resume: tick 2 cycles later.
    do_reset();
    drive(1, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 1, 0, 0, 1, 0);
    repeat (LAT) idle(1);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("pause_tick", int'(tick), 0);
      chk("pause_count", int'(count), 0);
    end
    drive(1, 0, 0, 0, 1, 0);
    k = 0;
    seen = tick;
    while (!seen && k < 12) begin
      idle(1);
      k++;
      seen = tick;
    end
    chk("resume_latency", seen ? k : -1, 2 + LAT);
    chk("resume_count", int'(count), 1);

    // Asynchronous reset mid-prescale with count 37.
    do_reset();
    drive(1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 37);
    repeat (LAT + 2) idle(1);
    chk("pre_reset_count", int'(count), 37);
    #2;
    rst = 0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_tick", int'(tick), 0);
    chk("async_wrap", int'(wrap), 0);
    chk("async_running", int'(running), 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      chk("post_reset_idle", int'(running), 0);
    end
    drive(1, 0, 0, 0, 1, 0);
    k = 0;
    seen = tick;
    while (!seen && k < 20) begin
      idle(1);
      k++;
      seen = tick;
    end
    chk("first_tick_latency", seen ? k : -1, DIV + LAT);

    // Randomized traffic against the reference model.
    do_reset();
    begin
      bit u;
      u = 1;
      for (int i = 0; i < 1500; i++) begin
        bit s, p, c, l;
        if ($urandom_range(0, 99) < 5) u = ~u;
        s = ($urandom_range(0, 99) < 15);
        p = ($urandom_range(0, 99) < 6);
        c = ($urandom_range(0, 199) < 3);
        l = ($urandom_range(0, 99) < 4);
        drive(s, p, c, l, u, int'($urandom_range(0, 63)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
